// File: rtl/mtr_drv_pwm.sv
// Dual H-bridge PWM generator with per-period duty latching, dead time and over-current shutdown.
// Optional over-current logic is built only when OVR_I_SHTDWN_EN is defined.
module mtr_drv_pwm #(
  parameter logic [5:0] DEAD      = 6'd32,
  parameter logic [7:0] BLANK     = 8'd128,
  parameter logic [4:0] OVR_LIMIT = 5'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        ovr_i,
  output logic        lft_pwm1,
  output logic        lft_pwm2,
  output logic        rght_pwm1,
  output logic        rght_pwm2,
  output logic        pwm_synch,
  output logic        ovr_i_shtdwn
);

  localparam int unsigned CW = 11;
  localparam int unsigned SW = 12;
  localparam int unsigned DW = 6;
  localparam int unsigned NS = 2;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DUTY_MID = CW'(1024);

  logic [CW-1:0]         cnt;
  logic                  end_c;
  logic [NS-1:0][SW-1:0] spd;
  logic [NS-1:0][CW-1:0] duty_q;
  logic [NS-1:0]         sig_c;
  logic [NS-1:0]         sig_d;
  logic [NS-1:0]         edge_c;
  logic [NS-1:0][DW-1:0] dead;
  logic [NS-1:0][DW-1:0] dead_n;
  logic [NS-1:0]         pwm1_q;
  logic [NS-1:0]         pwm2_q;
  logic                  shut;
  logic [NS-1:0]         unused_lsb;

  // Index 0 is the left side, index 1 the right side; speed LSB is dropped by the mapping.
  assign spd        = {rght_spd, lft_spd};
  assign unused_lsb = {spd[1][0], spd[0][0]};
  assign end_c      = (cnt == CNT_MAX);

  // Period counter, sync pulse and once-per-period duty latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pwm_synch <= 1'b0;
      duty_q    <= {NS{DUTY_MID}};
    end else begin
      cnt       <= cnt + CW'(1);
      pwm_synch <= end_c;
      if (end_c) begin
        for (int i = 0; i < NS; i++) begin
          duty_q[i] <= spd[i][SW-1:1] + DUTY_MID;
        end
      end
    end
  end

  // Raw PWM compare, edge detect and dead-time reload.
  always_comb begin
    sig_c  = '0;
    edge_c = '0;
    dead_n = '0;
    for (int i = 0; i < NS; i++) begin
      sig_c[i]  = (cnt < duty_q[i]);
      edge_c[i] = sig_c[i] ^ sig_d[i];
      if (edge_c[i]) begin
        dead_n[i] = DEAD;
      end else if (dead[i] != '0) begin
        dead_n[i] = dead[i] - DW'(1);
      end
    end
  end

  // pwm1/pwm2 are decoded from one sig bit, so they can never both be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d  <= '0;
      dead   <= '0;
      pwm1_q <= '0;
      pwm2_q <= '0;
    end else begin
      sig_d <= sig_c;
      dead  <= dead_n;
      for (int i = 0; i < NS; i++) begin
        pwm1_q[i] <= ~shut &  sig_c[i] & (dead_n[i] == '0);
        pwm2_q[i] <= ~shut & ~sig_c[i] & (dead_n[i] == '0);
      end
    end
  end

  assign lft_pwm1  = pwm1_q[0];
  assign lft_pwm2  = pwm2_q[0];
  assign rght_pwm1 = pwm1_q[1];
  assign rght_pwm2 = pwm2_q[1];

`ifdef OVR_I_SHTDWN_EN
  localparam int unsigned BW = 8;
  localparam int unsigned OW = 5;

  logic [NS-1:0][BW-1:0] age;
  logic                  armed_c;
  logic                  hit_c;
  logic                  flag;
  logic [OW-1:0]         ovr_cnt;
  logic                  shtdwn_q;

  // ovr_i only counts once a high side has been on for at least BLANK clocks.
  always_comb begin
    armed_c = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (sig_c[i] && (age[i] >= BLANK)) armed_c = 1'b1;
    end
    hit_c = armed_c & ovr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age      <= '0;
      flag     <= 1'b0;
      ovr_cnt  <= '0;
      shtdwn_q <= 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (!sig_c[i]) begin
          age[i] <= '0;
        end else if (age[i] != BLANK) begin
          age[i] <= age[i] + BW'(1);
        end
      end
      if (end_c) begin
        flag <= 1'b0;
        if (flag | hit_c) begin
          if (ovr_cnt != OVR_LIMIT) ovr_cnt <= ovr_cnt + OW'(1);
        end else begin
          ovr_cnt <= '0;
        end
      end else begin
        flag <= flag | hit_c;
      end
      if (ovr_cnt == OVR_LIMIT) shtdwn_q <= 1'b1;
    end
  end

  assign shut         = shtdwn_q;
  assign ovr_i_shtdwn = shtdwn_q;
`else
  logic [13:0] unused_cfg;

  assign unused_cfg   = {ovr_i, BLANK, OVR_LIMIT};
  assign shut         = 1'b0;
  assign ovr_i_shtdwn = 1'b0;
`endif

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Directed bench for mtr_drv_pwm: per-period pulse counts, dead-time gaps, duty latching and shutdown.
module tb_mtr_drv_pwm;

  logic        clk;
  logic        rst;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        ovr_i;
  logic        lft_pwm1;
  logic        lft_pwm2;
  logic        rght_pwm1;
  logic        rght_pwm2;
  logic        pwm_synch;
  logic        ovr_i_shtdwn;

  mtr_drv_pwm dut (
    .clk          (clk),
    .rst          (rst),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .ovr_i        (ovr_i),
    .lft_pwm1     (lft_pwm1),
    .lft_pwm2     (lft_pwm2),
    .rght_pwm1    (rght_pwm1),
    .rght_pwm2    (rght_pwm2),
    .pwm_synch    (pwm_synch),
    .ovr_i_shtdwn (ovr_i_shtdwn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    int          p1l;
    int          p2l;
    int          p1r;
    int          p2r;
    int          gap;
    string       name;
  } vec_t;

  vec_t vecs [5];

  int n_chk   = 0;
  int n_pass  = 0;
  int overlap = 0;
  int c1l, c2l, c1r, c2r, w_len, gmin, gmax, run;

  always @(negedge clk) begin
    if ((lft_pwm1 && lft_pwm2) || (rght_pwm1 && rght_pwm2)) overlap++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Called on a sync sample; counts high samples per output up to the next sync sample.
  task automatic run_window(input int chg_at, input logic [11:0] chg_val, input int ovr_at);
    int k = 0;
    c1l = 0; c2l = 0; c1r = 0; c2r = 0;
    gmin = 99999; gmax = 0; run = 0;
    do begin
      c1l += int'(lft_pwm1);
      c2l += int'(lft_pwm2);
      c1r += int'(rght_pwm1);
      c2r += int'(rght_pwm2);
      if (!lft_pwm1 && !lft_pwm2) begin
        run++;
      end else begin
        if (run > 0) begin
          if (run < gmin) gmin = run;
          if (run > gmax) gmax = run;
        end
        run = 0;
      end
      if (k == chg_at) lft_spd = chg_val;
      if (ovr_at >= 0) begin
        if (k == ovr_at) ovr_i = 1'b1;
        else if (k == ovr_at + 1) ovr_i = 1'b0;
      end
      k++;
      @(negedge clk);
    end while (!pwm_synch && k < 2100);
    w_len = k;
    if (!pwm_synch) check("sync_timeout", 0, 1);
  endtask

  task automatic do_reset(input string tag);
    int k  = 0;
    int p1 = 0;
    int p2 = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_outs"}, int'({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_synch, ovr_i_shtdwn}), 0);
    rst = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (!pwm_synch) begin
        p1 += int'(lft_pwm1);
        p2 += int'(lft_pwm2);
      end
    end while (!pwm_synch && k < 3000);
    check({tag, "_first_sync"}, k, 2048);
    check({tag, "_first_p1l"}, p1, 992);
    check({tag, "_first_p2l"}, p2, 991);
  endtask

  initial begin
    rst      = 1'b1;
    lft_spd  = 12'h000;
    rght_spd = 12'h000;
    ovr_i    = 1'b0;

    vecs[0] = '{12'h000, 12'h000,  992,  992,  992,  992, 32, "zero"};
    vecs[1] = '{12'h3E8, 12'hC18, 1492,  492,  492, 1492, 32, "pm1000"};
    vecs[2] = '{12'hFFF, 12'h002,  991,  993,  993,  991, 32, "lsb"};
    vecs[3] = '{12'h7FF, 12'h800, 2015,    0,    0, 2048,  0, "extremes"};
    vecs[4] = '{12'h040, 12'h830, 1024,  960,    0, 1992, 32, "narrow"};

    do_reset("rst");

`ifndef OVR_I_SHTDWN_EN
    ovr_i = 1'b1;
`endif

    // Each vector: one transition window, then a steady window measured while the next is applied.
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        lft_spd  = vecs[i].l;
        rght_spd = vecs[i].r;
      end
      run_window(-1, 12'h000, -1);
      if (i > 0) begin
        check($sformatf("%s_len", vecs[i-1].name), w_len, 2048);
        check($sformatf("%s_p1l", vecs[i-1].name), c1l, vecs[i-1].p1l);
        check($sformatf("%s_p2l", vecs[i-1].name), c2l, vecs[i-1].p2l);
        check($sformatf("%s_p1r", vecs[i-1].name), c1r, vecs[i-1].p1r);
        check($sformatf("%s_p2r", vecs[i-1].name), c2r, vecs[i-1].p2r);
        if (vecs[i-1].gap != 0) begin
          check($sformatf("%s_gap_min", vecs[i-1].name), gmin, vecs[i-1].gap);
          check($sformatf("%s_gap_max", vecs[i-1].name), gmax, vecs[i-1].gap);
        end
      end
      if (i < 5) run_window(-1, 12'h000, -1);
    end

    // Full-scale duty, then a mid-period change to full negative.
    lft_spd  = 12'h7FF;
    rght_spd = 12'h000;
    run_window(-1, 12'h000, -1);
    run_window(500, 12'h800, -1);
    check("t2_hold_p1l", c1l, 2015);
    run_window(-1, 12'h000, -1);
    check("t2_zero_p1l", c1l, 0);
    check("t2_zero_p2l", c2l, 2016);
    run_window(-1, 12'h000, -1);
    check("t2_steady_p1l", c1l, 0);
    check("t2_steady_p2l", c2l, 2048);

`ifdef OVR_I_SHTDWN_EN
    lft_spd = 12'h000;
    run_window(-1, 12'h000, -1);
    for (int p = 0; p < 15; p++) run_window(-1, 12'h000, 200);
    check("ovr_15a_shtdwn", int'(ovr_i_shtdwn), 0);
    run_window(-1, 12'h000, 100);
    check("ovr_blank_shtdwn", int'(ovr_i_shtdwn), 0);
    for (int p = 0; p < 15; p++) run_window(-1, 12'h000, 200);
    check("ovr_15b_shtdwn", int'(ovr_i_shtdwn), 0);
    run_window(-1, 12'h000, 200);
    run_window(-1, 12'h000, -1);
    check("shtdwn_set", int'(ovr_i_shtdwn), 1);
    check("shtdwn_p1l", c1l, 0);
    check("shtdwn_p2l", c2l, 1);
    check("shtdwn_p1r", c1r, 0);
    check("shtdwn_p2r", c2r, 1);
    run_window(-1, 12'h000, -1);
    check("shtdwn_sticky", int'(ovr_i_shtdwn), 1);
    check("shtdwn_all_low", c1l + c2l + c1r + c2r, 0);
    do_reset("rst2");
`else
    for (int p = 0; p < 2; p++) begin
      run_window(-1, 12'h000, -1);
      check("ovr_ign_p2l", c2l, 2048);
      check("ovr_ign_p1r", c1r, 992);
    end
    check("ovr_ign_shtdwn", int'(ovr_i_shtdwn), 0);
`endif

    check("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
